// File: rtl/product_accumulator.sv
// ============================================================================
// Module   : product_accumulator
// Purpose  : Accumulates a valid/last stream of signed products into a wide
//            register. At the end of each frame the sum is rounded (half
//            toward +inf), arithmetically shifted right by SHIFT and
//            saturated to OW bits. The result is presented on a single-entry
//            valid/ready output register.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            in_valid/in_ready/in_data/in_last - product stream
//            out_valid/out_ready               - result handshake
//            out_data        - rounded/saturated frame sum (signed, OW bits)
//            out_sat         - out_data was clipped
//            out_cnt         - number of products in the frame (saturating)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module product_accumulator #(
  parameter int MW    = 35,
  parameter int ACCW  = 48,
  parameter int OW    = 24,
  parameter int SHIFT = 16,
  parameter int CW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [MW-1:0] in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_data,
  output logic                 out_sat,
  output logic [CW-1:0]        out_cnt
);

  // Saturation bounds, held one bit wider than the accumulator so they can be
  // compared directly against the rounded value.
  localparam logic signed [ACCW:0] c_one = (ACCW+1)'(1);
  localparam logic signed [ACCW:0] c_max = (c_one <<< (OW-1)) - c_one;
  localparam logic signed [ACCW:0] c_min = ~c_max;

  // State registers
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   first_q, first_d;
  logic                   out_valid_q, out_valid_d;
  logic signed [OW-1:0]   out_data_q, out_data_d;
  logic                   out_sat_q, out_sat_d;
  logic [CW-1:0]          out_cnt_q, out_cnt_d;

  // Datapath wires
  logic                   w_accept;
  logic signed [ACCW-1:0] w_ext;
  logic signed [ACCW-1:0] w_sum;
  logic [CW-1:0]          w_n;
  logic signed [ACCW:0]   w_wide;
  logic signed [ACCW:0]   w_rnd;
  logic signed [OW-1:0]   w_res;
  logic                   w_clip;

  // The output register can take a new result whenever it is empty or being
  // drained this cycle, so no result is ever overwritten.
  assign in_ready = !out_valid_q || out_ready;
  assign w_accept = in_valid && in_ready;

  // Sign extension happens through the signed size cast.
  assign w_ext = ACCW'(in_data);

  // A frame's first product discards whatever the accumulator holds, so the
  // running sum never needs an explicit clear cycle between frames.
  assign w_sum = (first_q ? '0 : acc_q) + w_ext;

  // Product count saturates at all-ones rather than wrapping.
  assign w_n = first_q           ? CW'(1) :
               (cnt_q == '1)     ? cnt_q  :
                                   cnt_q + CW'(1);

  // One guard bit above the accumulator keeps the rounding add from wrapping.
  assign w_wide = {w_sum[ACCW-1], w_sum};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [ACCW:0] c_half = c_one <<< (SHIFT-1);
      assign w_rnd = (w_wide + c_half) >>> SHIFT;
    end else begin : g_no_round
      assign w_rnd = w_wide;
    end
  endgenerate

  always_comb begin
    w_clip = 1'b0;
    w_res  = w_rnd[OW-1:0];
    if (w_rnd > c_max) begin
      w_clip = 1'b1;
      w_res  = c_max[OW-1:0];
    end else if (w_rnd < c_min) begin
      w_clip = 1'b1;
      w_res  = c_min[OW-1:0];
    end
  end

  // Next-state logic
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_cnt_d   = out_cnt_q;

    // Result drained; payload is left in place.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (w_accept) begin
      if (in_last) begin
        // A last accept overrides the drain above, so back-to-back results
        // flow without a bubble.
        acc_d       = '0;
        cnt_d       = '0;
        first_d     = 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = w_res;
        out_sat_d   = w_clip;
        out_cnt_d   = w_n;
      end else begin
        acc_d   = w_sum;
        cnt_d   = w_n;
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_cnt_q   <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_cnt   = out_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// ============================================================================
// Module   : tb_product_accumulator
// Purpose  : Self-checking bench for product_accumulator. A reference model
//            collects each frame's products, sums them with plain integer
//            arithmetic and queues the expected result; a monitor compares
//            the DUT output against the queue head whenever a result is held.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_product_accumulator;

  localparam int MW    = 35;
  localparam int ACCW  = 48;
  localparam int OW    = 24;
  localparam int SHIFT = 16;
  localparam int CW    = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic signed [MW-1:0] in_data;
  logic                 in_last;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic                 out_sat;
  logic [CW-1:0]        out_cnt;

  always #5 clk = ~clk;

  product_accumulator #(
    .MW(MW), .ACCW(ACCW), .OW(OW), .SHIFT(SHIFT), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .out_cnt(out_cnt)
  );

  typedef struct {
    longint d;
    longint s;
    longint c;
  } res_t;

  res_t   exp_q[$];
  longint frame_q[$];
  bit     pushed_now;
  bit     rand_done;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: exact integer sum, wrapped to ACCW bits, rounded half up,
  // divided by 2^SHIFT (floor), then clamped to the OW-bit signed range.
  function automatic res_t model_frame();
    res_t   r;
    longint s = 0;
    longint y;
    longint lmax = (longint'(1) <<< (OW-1)) - 1;
    longint lmin = -lmax - 1;
    foreach (frame_q[i]) s += frame_q[i];
    s = (s <<< (64-ACCW)) >>> (64-ACCW);
    y = (s + (longint'(1) <<< (SHIFT-1))) >>> SHIFT;
    r.s = 0;
    if (y > lmax) begin y = lmax; r.s = 1; end
    else if (y < lmin) begin y = lmin; r.s = 1; end
    r.d = y;
    r.c = (frame_q.size() > 65535) ? 65535 : frame_q.size();
    return r;
  endfunction

  // Model: watch accepted products at the stable mid-cycle point.
  always @(negedge clk) begin
    pushed_now = 1'b0;
    if (!rst && in_valid && in_ready) begin
      frame_q.push_back(longint'(in_data));
      if (in_last) begin
        exp_q.push_back(model_frame());
        frame_q.delete();
        pushed_now = 1'b1;
      end
    end
  end

  // Monitor: a result pushed this cycle appears on the output next cycle.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      chk("in_ready rule", longint'(in_ready), longint'(!out_valid || out_ready));
      chk("out_valid", longint'(out_valid),
          longint'((exp_q.size() - int'(pushed_now)) > 0));
      if (out_valid && exp_q.size() > 0) begin
        chk("out_data", longint'(out_data), exp_q[0].d);
        chk("out_sat",  longint'(out_sat),  exp_q[0].s);
        chk("out_cnt",  longint'(out_cnt),  exp_q[0].c);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input longint d, input bit last);
    int t = 0;
    bit ok;
    in_valid = 1'b1;
    in_data  = d[MW-1:0];
    in_last  = last;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < 200);
    if (!ok) chk("send timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'($urandom);
    in_data  = MW'($urandom);
  endtask

  task automatic expect_res(input string name, input longint d, input longint s,
                            input longint c);
    int t = 0;
    @(negedge clk);
    #2;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk({name, " valid"}, longint'(out_valid), 1);
    chk({name, " data"},  longint'(out_data), d);
    chk({name, " sat"},   longint'(out_sat), s);
    chk({name, " cnt"},   longint'(out_cnt), c);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst out_valid", longint'(out_valid), 0);
    chk("async rst in_ready",  longint'(in_ready), 1);
    exp_q.delete();
    frame_q.delete();
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    rand_done = 1'b0;

    // Reset held with random inputs
    repeat (5) begin
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom);
      in_last   = 1'($urandom);
      in_data   = MW'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      #2;
      chk("rst out_valid", longint'(out_valid), 0);
      chk("rst out_data",  longint'(out_data), 0);
      chk("rst out_sat",   longint'(out_sat), 0);
      chk("rst out_cnt",   longint'(out_cnt), 0);
      chk("rst in_ready",  longint'(in_ready), 1);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(3);
    chk("post-rst out_data", longint'(out_data), 0);
    chk("post-rst out_cnt",  longint'(out_cnt), 0);

    // Basic frame and single-sample frames
    send(65536, 0);
    send(131072, 0);
    send(-32768, 1);
    expect_res("frame3", 3, 0, 3);
    idle(2);
    send(98304, 1);
    expect_res("single+", 2, 0, 1);
    idle(2);
    send(-98304, 1);
    expect_res("single-", -1, 0, 1);
    idle(2);

    // Saturation both directions
    for (int i = 0; i < 40; i++) send(64'sd17179869183, i == 39);
    expect_res("sat+", 8388607, 1, 40);
    idle(2);
    for (int i = 0; i < 40; i++) send(-64'sd17179869184, i == 39);
    expect_res("sat-", -8388608, 1, 40);
    idle(2);

    // Backpressure: result held, next frame's first product stalls
    out_ready = 1'b0;
    send(98304, 1);
    fork
      begin
        send(65536, 0);
        send(131072, 1);
      end
      begin
        repeat (10) begin
          @(negedge clk);
          #2;
          chk("stall in_ready", longint'(in_ready), 0);
          chk("stall out_data", longint'(out_data), 2);
          chk("stall out_cnt",  longint'(out_cnt), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    expect_res("after stall", 3, 0, 2);
    idle(2);

    // Back-to-back single-sample frames
    send(65536, 1);
    send(131072, 1);
    send(196608, 1);
    expect_res("b2b third", 3, 0, 1);
    idle(2);

    // Reset with a pending result, then with a partial frame
    out_ready = 1'b0;
    send(98304, 1);
    reset_pulse();
    out_ready = 1'b1;
    idle(1);
    send(65536, 0);
    send(65536, 0);
    reset_pulse();
    idle(1);
    send(65536, 1);
    expect_res("after mid rst", 1, 0, 1);
    idle(2);

    // Randomized frames with random gaps and backpressure
    fork
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int f = 0; f < 150; f++) begin
          int len = $urandom_range(1, 6);
          for (int k = 0; k < len; k++) begin
            longint r = longint'({$urandom(), $urandom()});
            if ($urandom_range(0, 1) == 0) r = r >>> 40;
            in_last = 1'($urandom);
            idle($urandom_range(0, 2));
            send(r, k == len - 1);
          end
        end
        rand_done = 1'b1;
      end
    join
    out_ready = 1'b1;
    idle(6);
    chk("scoreboard drained", exp_q.size(), 0);
    chk("no partial frame",   frame_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
